// File: rtl/game_ctrl.sv
// game_ctrl: game-level sequencer sitting between the debounced start button
// and the round engine. It launches rounds back to back with a pause between
// them, counts hits per round, moves the difficulty level up or takes a life
// after each round, keeps the score and declares game over.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for start after reset
// S_LAUNCH    | one-cycle round_start pulse, config already stable
// S_WAIT_BUSY | waiting for the engine to leave idle (round_over low)
// S_WAIT_DONE | round in progress, waiting for round_over to rise
// S_EVAL      | one cycle: level up, or take a life, reload config
// S_GAP       | pause of GAP_CYCLES cycles before the next launch
// S_OVER      | out of lives; score/level/lives frozen until start
module game_ctrl #(
    parameter int unsigned MOLES_PER_ROUND = 5,
    parameter int unsigned PASS_HITS       = 3,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned MAX_LEVEL       = 9,
    parameter int unsigned BASE_INTERVAL   = 50_000_000,
    parameter int unsigned BASE_DURATION   = 75_000_000,
    parameter int unsigned DUR_STEP        = 6_000_000,
    parameter int unsigned INT_STEP        = 4_000_000,
    parameter int unsigned MIN_DURATION    = 15_000_000,
    parameter int unsigned MIN_INTERVAL    = 10_000_000,
    parameter int unsigned GAP_CYCLES      = 25_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_round_over,
    input  logic        i_hit_success,
    output logic        o_round_start,
    output logic [26:0] o_interval,
    output logic [26:0] o_duration,
    output logic [2:0]  o_molenum,
    output logic [9:0]  o_score,
    output logic [3:0]  o_level,
    output logic [1:0]  o_lives,
    output logic [2:0]  o_round_hits,
    output logic        o_game_active,
    output logic        o_game_over
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0] LP_MAX_LEVEL = 4'(MAX_LEVEL);
    localparam logic [2:0] LP_PASS_HITS = 3'(PASS_HITS);
    localparam logic [1:0] LP_LIVES     = 2'(LIVES);
    localparam logic [9:0] LP_MAX_SCORE = 10'd999;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_EVAL,
        S_GAP,
        S_OVER
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [9:0]      r_score;
    logic [3:0]      r_level;
    logic [1:0]      r_lives;
    logic [2:0]      r_round_hits;
    logic [26:0]     r_interval;
    logic [26:0]     r_duration;
    logic            r_round_start;
    logic            r_game_active;
    logic            r_game_over;
    logic [GW-1:0]   r_gap_cnt;

    logic            w_pass;
    logic            w_gap_done;
    logic            w_hit;
    logic            w_restart;
    logic [3:0]      w_level_nxt;

    // base - L*step, floored at the minimum; the floor is taken before the
    // subtraction could go negative, so a large level never wraps around
    function automatic logic [26:0] f_cfg(input logic [31:0] base,
                                          input logic [31:0] step,
                                          input logic [31:0] floor_v,
                                          input logic [3:0]  lvl);
        logic [31:0] prod;
        logic [31:0] diff;
        prod = 32'(lvl) * step;
        if (prod >= base - floor_v) begin
            diff = floor_v;
        end else begin
            diff = base - prod;
        end
        return diff[26:0];
    endfunction

    assign w_pass      = (r_round_hits >= LP_PASS_HITS);
    assign w_gap_done  = (r_gap_cnt == GW'(GAP_CYCLES - 1));
    assign w_hit       = i_hit_success &&
                         ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE));
    assign w_restart   = i_start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_level_nxt = (w_pass && (r_level < LP_MAX_LEVEL)) ? r_level + 4'd1 : r_level;

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_OVER: if (i_start) w_next = S_LAUNCH;
            S_LAUNCH:       w_next = S_WAIT_BUSY;
            S_WAIT_BUSY:    if (!i_round_over) w_next = S_WAIT_DONE;
            S_WAIT_DONE:    if (i_round_over) w_next = S_EVAL;
            S_EVAL: begin
                if (w_pass) begin
                    w_next = S_GAP;
                end else if (r_lives == 2'd1) begin
                    w_next = S_OVER;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_GAP:          if (w_gap_done) w_next = S_LAUNCH;
            default:        w_next = S_IDLE;
        endcase
    end

    // game registers and flags; flags follow the next state so they line up
    // with the state register cycle for cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_score       <= '0;
            r_level       <= '0;
            r_lives       <= LP_LIVES;
            r_round_hits  <= '0;
            r_interval    <= 27'(BASE_INTERVAL);
            r_duration    <= 27'(BASE_DURATION);
            r_round_start <= 1'b0;
            r_game_active <= 1'b0;
            r_game_over   <= 1'b0;
            r_gap_cnt     <= '0;
        end else begin
            r_round_start <= (w_next == S_LAUNCH);
            r_game_active <= (w_next == S_LAUNCH) || (w_next == S_WAIT_BUSY) ||
                             (w_next == S_WAIT_DONE) || (w_next == S_EVAL) ||
                             (w_next == S_GAP);
            r_game_over   <= (w_next == S_OVER);

            if (w_restart) begin
                r_score    <= '0;
                r_level    <= '0;
                r_lives    <= LP_LIVES;
                r_interval <= f_cfg(32'(BASE_INTERVAL), 32'(INT_STEP), 32'(MIN_INTERVAL), 4'd0);
                r_duration <= f_cfg(32'(BASE_DURATION), 32'(DUR_STEP), 32'(MIN_DURATION), 4'd0);
            end

            if (w_next == S_LAUNCH) begin
                r_round_hits <= '0;
            end else if (w_hit) begin
                if (r_round_hits != 3'd7) r_round_hits <= r_round_hits + 3'd1;
            end

            if (w_hit && (r_score != LP_MAX_SCORE)) begin
                r_score <= r_score + 10'd1;
            end

            if (r_state == S_EVAL) begin
                r_level    <= w_level_nxt;
                r_interval <= f_cfg(32'(BASE_INTERVAL), 32'(INT_STEP), 32'(MIN_INTERVAL), w_level_nxt);
                r_duration <= f_cfg(32'(BASE_DURATION), 32'(DUR_STEP), 32'(MIN_DURATION), w_level_nxt);
                if (!w_pass) r_lives <= r_lives - 2'd1;
            end

            if (r_state == S_GAP) begin
                r_gap_cnt <= w_gap_done ? '0 : r_gap_cnt + GW'(1);
            end
        end
    end

    assign o_round_start = r_round_start;
    assign o_interval    = r_interval;
    assign o_duration    = r_duration;
    assign o_molenum     = 3'(MOLES_PER_ROUND);
    assign o_score       = r_score;
    assign o_level       = r_level;
    assign o_lives       = r_lives;
    assign o_round_hits  = r_round_hits;
    assign o_game_active = r_game_active;
    assign o_game_over   = r_game_over;

endmodule
